// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers words in a FIFO and feeds them LSB byte first to a UART transmitter.
// Define UART_TX_FEEDER_WCNT_EN to add the o_words_sent completed-word counter.
module uart_tx_feeder #(
    parameter int NB_DATA    = 8,
    parameter int NB_WORD    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          i_rst,
    input  logic [NB_WORD-1:0]            i_word,
    input  logic                          i_word_valid,
    output logic                          o_word_ready,
    output logic [NB_DATA-1:0]            o_data,
    output logic                          o_tx_start,
    input  logic                          i_tx_done,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
`ifdef UART_TX_FEEDER_WCNT_EN
    ,
    output logic [15:0]                   o_words_sent
`endif
);
    localparam int NB_ADDR  = $clog2(FIFO_DEPTH);
    localparam int NB_BYTES = NB_WORD / NB_DATA;
    localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t             state_q;
    logic [NB_WORD-1:0] mem_q [FIFO_DEPTH];
    logic [NB_ADDR-1:0] wr_ptr_q, rd_ptr_q;
    logic [NB_ADDR:0]   count_q, count_d;
    logic [NB_WORD-1:0] shift_q;
    logic [NB_BCNT-1:0] bcnt_q;
    logic               tx_start_q;
    logic               push, pop, last_byte;

    assign o_word_ready = count_q != (NB_ADDR+1)'(FIFO_DEPTH);
    assign push         = i_word_valid && o_word_ready;
    // Popping only from IDLE with a non-empty FIFO keeps the head valid and distinct from the write slot.
    assign pop          = (state_q == IDLE) && (count_q != '0);
    assign last_byte    = bcnt_q == NB_BCNT'(NB_BYTES - 1);
    assign count_d      = count_q + {{NB_ADDR{1'b0}}, push} - {{NB_ADDR{1'b0}}, pop};

    assign o_data       = shift_q[NB_DATA-1:0];
    assign o_tx_start   = tx_start_q;
    assign o_fifo_count = count_q;
    assign o_busy       = (count_q != '0) || (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= i_word;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= push ? wr_ptr_q + NB_ADDR'(1) : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + NB_ADDR'(1) : rd_ptr_q;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcnt_q     <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: if (pop) begin
                    shift_q    <= mem_q[rd_ptr_q];
                    bcnt_q     <= '0;
                    tx_start_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: state_q <= WAIT;
                WAIT: if (i_tx_done) begin
                    if (last_byte) begin
                        state_q <= IDLE;
                    end else begin
                        shift_q    <= shift_q >> NB_DATA;
                        bcnt_q     <= bcnt_q + NB_BCNT'(1);
                        tx_start_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef UART_TX_FEEDER_WCNT_EN
    logic [15:0] words_q;

    assign o_words_sent = words_q;

    always_ff @(posedge clk) begin
        if (i_rst) words_q <= '0;
        else if (state_q == WAIT && i_tx_done && last_byte) words_q <= words_q + 16'd1;
    end
`endif
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench; accepted words queue their bytes, a monitor checks each start.
module tb_uart_tx_feeder;
    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_word = '0;
    logic        i_word_valid = 1'b0;
    logic        o_word_ready;
    logic [7:0]  o_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_busy;
    logic [2:0]  o_fifo_count;
`ifdef UART_TX_FEEDER_WCNT_EN
    logic [15:0] o_words_sent;
`endif
    logic        man_done = 1'b0, resp_done = 1'b0;
    bit          auto_done = 1'b0;
    int          total = 0, bad = 0, starts = 0, accepted = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  resp_held;
    bit          resp_unstable, resp_abort;
    int          resp_d;

    assign i_tx_done = man_done | resp_done;

    always #5 clk = ~clk;

    uart_tx_feeder #(.NB_DATA(8), .NB_WORD(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .i_rst(i_rst), .i_word(i_word), .i_word_valid(i_word_valid),
        .o_word_ready(o_word_ready), .o_data(o_data), .o_tx_start(o_tx_start),
        .i_tx_done(i_tx_done), .o_busy(o_busy), .o_fifo_count(o_fifo_count)
`ifdef UART_TX_FEEDER_WCNT_EN
        , .o_words_sent(o_words_sent)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: every accepted word contributes its four bytes, lowest first.
    always @(negedge clk) begin
        if (i_word_valid && o_word_ready && !i_rst) begin
            accepted++;
            for (int k = 0; k < 4; k++) exp_q.push_back(i_word[8*k +: 8]);
        end
        if (o_tx_start && !i_rst) begin
            starts++;
            if (exp_q.size() == 0) check("unexpected_start", {24'd0, o_data}, 32'hdead);
            else check("byte", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
        end
    end

    // Transmitter stand-in: answers each start with one done tick after a random delay.
    initial forever begin
        @(negedge clk);
        while (o_tx_start && auto_done && !i_rst) begin
            resp_held = o_data;
            resp_unstable = 0;
            resp_abort = 0;
            resp_d = $urandom_range(8, 1);
            repeat (resp_d) begin
                @(negedge clk);
                if (i_rst) resp_abort = 1;
                if (o_data !== resp_held) resp_unstable = 1;
            end
            if (resp_abort) break;
            check("data_stable", {31'd0, resp_unstable}, 32'd0);
            resp_done = 1'b1;
            @(negedge clk);
            resp_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] w);
        bit acc = 0;
        i_word = w;
        i_word_valid = 1'b1;
        for (int n = 0; n < 2000 && !acc; n++) begin
            acc = o_word_ready;
            tick();
        end
        i_word_valid = 1'b0;
        if (!acc) check("put_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_done(input int n);
        repeat (n) tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20000 && o_busy; n++) tick();
        check("drain_busy", {31'd0, o_busy}, 32'd0);
        check("drain_queue", exp_q.size(), 32'd0);
    endtask

    initial begin
        int s0, a0;
        logic [31:0] ref_bytes;
        repeat (3) tick();
        i_rst = 1'b0;
        check("rst_ready", {31'd0, o_word_ready}, 32'd1);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_start", {31'd0, o_tx_start}, 32'd0);
        check("rst_data", {24'd0, o_data}, 32'd0);
        check("rst_count", {29'd0, o_fifo_count}, 32'd0);

        // Single word with done 20 cycles after each start.
        ref_bytes = 32'ha1b2c3d4;
        put_word(ref_bytes);
        check("lat_count", {29'd0, o_fifo_count}, 32'd1);
        check("lat_nostart", {31'd0, o_tx_start}, 32'd0);
        check("lat_busy", {31'd0, o_busy}, 32'd1);
        tick();
        check("lat_start", {31'd0, o_tx_start}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            repeat (20) tick();
            check("hold_data", {24'd0, o_data}, {24'd0, ref_bytes[8*k +: 8]});
            check("hold_nostart", {31'd0, o_tx_start}, 32'd0);
            man_done = 1'b1;
            tick();
            man_done = 1'b0;
            if (k < 3) check("next_start", {31'd0, o_tx_start}, 32'd1);
            else check("end_busy", {31'd0, o_busy}, 32'd0);
        end

        // Spurious done in IDLE and in the SEND cycle.
        s0 = starts;
        do_done(0);
        repeat (3) tick();
        check("idle_done_busy", {31'd0, o_busy}, 32'd0);
        check("idle_done_starts", starts - s0, 32'd0);
        put_word(32'h55667788);
        tick();
        check("send_start", {31'd0, o_tx_start}, 32'd1);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (4) tick();
        check("send_done_starts", starts - s0, 32'd1);
        check("send_done_data", {24'd0, o_data}, 32'h88);
        do_done(2);
        check("after_send_data", {24'd0, o_data}, 32'h77);
        for (int k = 0; k < 3; k++) do_done(2);
        check("spur_busy", {31'd0, o_busy}, 32'd0);

        // Fill with done held low.
        s0 = starts;
        a0 = accepted;
        for (int v = 1; v <= 6; v++) begin
            i_word = v;
            i_word_valid = 1'b1;
            tick();
        end
        i_word_valid = 1'b0;
        check("fill_accepted", accepted - a0, 32'd5);
        check("fill_ready", {31'd0, o_word_ready}, 32'd0);
        check("fill_count", {29'd0, o_fifo_count}, 32'd4);
        check("fill_starts", starts - s0, 32'd1);
        for (int k = 0; k < 4; k++) do_done(1);
        tick();
        check("pop_count", {29'd0, o_fifo_count}, 32'd3);
        put_word(32'd7);
        check("refill_count", {29'd0, o_fifo_count}, 32'd4);
        for (int k = 0; k < 4; k++) do_done(1);
        tick();
        for (int k = 0; k < 4; k++) do_done(1);
        check("pre_pp_count", {29'd0, o_fifo_count}, 32'd3);
        i_word = 32'd8;
        i_word_valid = 1'b1;
        tick();
        i_word_valid = 1'b0;
        check("pp_count", {29'd0, o_fifo_count}, 32'd3);
        check("pp_start", {31'd0, o_tx_start}, 32'd1);
        auto_done = 1'b1;
        drain();
`ifdef UART_TX_FEEDER_WCNT_EN
        check("wcnt_9", {16'd0, o_words_sent}, 32'd9);
`endif

        // Reset while the second byte is in flight with two words buffered.
        auto_done = 1'b0;
        put_word(32'ha0a1a2a3);
        put_word(32'hb0b1b2b3);
        put_word(32'hc0c1c2c3);
        do_done(1);
        check("mid_data", {24'd0, o_data}, 32'ha2);
        check("mid_count", {29'd0, o_fifo_count}, 32'd2);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_q.delete();
        check("mrst_count", {29'd0, o_fifo_count}, 32'd0);
        check("mrst_busy", {31'd0, o_busy}, 32'd0);
        check("mrst_start", {31'd0, o_tx_start}, 32'd0);
        check("mrst_ready", {31'd0, o_word_ready}, 32'd1);
        s0 = starts;
        repeat (10) tick();
        check("mrst_quiet", starts - s0, 32'd0);
        put_word(32'h11223344);
        tick();
        check("mrst_first", {24'd0, o_data}, 32'h44);
        auto_done = 1'b1;
        drain();

        // Random words with random gaps and random done delays.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(3, 0)) tick();
            put_word($urandom);
        end
        drain();
`ifdef UART_TX_FEEDER_WCNT_EN
        check("wcnt_31", {16'd0, o_words_sent}, 32'd31);
        force dut.words_q = 16'hffff;
        tick();
        release dut.words_q;
        put_word(32'hcafef00d);
        drain();
        check("wcnt_wrap", {16'd0, o_words_sent}, 32'd0);
`endif
        check("final_queue", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
